// File: rtl/des_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// des_key_sched_ctrl : iterative DES key schedule, one C/D register, streams
//                      K1..K16 (encrypt) or K16..K1 (decrypt) over valid/ready
// Revision 1.0
// ============================================================================
module des_key_sched_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [63:0] key,
    input  logic        decrypt,
    input  logic        abort,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic [47:0] rk,
    output logic [3:0]  rk_round,
    output logic        rk_last,
    output logic        busy
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    localparam int c_pc1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int c_pc2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Bit i set when shift-table entry s[i+1] is 2, otherwise the shift is 1.
    localparam logic [15:0] c_shift_two = 16'h7EFC;

    state_t      r_state;
    logic [55:0] r_cd;
    logic [3:0]  r_round;
    logic        r_dec;

    logic [55:0] w_pc1;
    logic [55:0] w_cd_rotl;
    logic [55:0] w_cd_rotr;
    logic [55:0] w_pc1_rotl1;
    logic        w_enc_two;
    logic        w_dec_two;
    logic        w_busy;
    logic        w_last;
    logic        w_unused_parity;

    function automatic logic [27:0] f_rotl(input logic [27:0] v, input logic two);
        return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
    endfunction

    function automatic logic [27:0] f_rotr(input logic [27:0] v, input logic two);
        return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
    endfunction

    // PC-1 output bit (i+1) lands at cd[55-i]; FIPS key bit n sits at key[n-1].
    for (genvar g = 0; g < 56; g++) begin : g_pc1
        assign w_pc1[55-g] = key[c_pc1[g]-1];
    end

    // PC-2 output bit (j+1) drives rk[47-j]; CD bit k sits at cd[56-k].
    for (genvar g = 0; g < 48; g++) begin : g_pc2
        assign rk[47-g] = r_cd[56-c_pc2[g]];
    end

    assign w_unused_parity = ^{key[63], key[55], key[47], key[39],
                               key[31], key[23], key[15], key[7]};

    // Encrypt advancing from round r uses s[r+2]; decrypt from r uses s[r+1].
    assign w_enc_two = c_shift_two[r_round + 4'd1];
    assign w_dec_two = c_shift_two[r_round];

    assign w_pc1_rotl1 = {f_rotl(w_pc1[55:28], 1'b0), f_rotl(w_pc1[27:0], 1'b0)};
    assign w_cd_rotl   = {f_rotl(r_cd[55:28], w_enc_two), f_rotl(r_cd[27:0], w_enc_two)};
    assign w_cd_rotr   = {f_rotr(r_cd[55:28], w_dec_two), f_rotr(r_cd[27:0], w_dec_two)};

    assign w_busy = (r_state == S_EMIT);
    assign w_last = w_busy && (r_round == (r_dec ? 4'd0 : 4'd15));

    assign busy      = w_busy;
    assign rk_valid  = w_busy;
    assign key_ready = !w_busy;
    assign rk_round  = r_round;
    assign rk_last   = w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cd    <= '0;
            r_round <= '0;
            r_dec   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (key_valid) begin
                        r_state <= S_EMIT;
                        r_dec   <= decrypt;
                        if (decrypt) begin
                            r_cd    <= w_pc1;
                            r_round <= 4'd15;
                        end else begin
                            r_cd    <= w_pc1_rotl1;
                            r_round <= 4'd0;
                        end
                    end
                end
                S_EMIT: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (rk_ready) begin
                        if (w_last) begin
                            r_state <= S_IDLE;
                        end else if (r_dec) begin
                            r_cd    <= w_cd_rotr;
                            r_round <= r_round - 4'd1;
                        end else begin
                            r_cd    <= w_cd_rotl;
                            r_round <= r_round + 4'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_des_key_sched_ctrl.sv
`default_nettype none
// Directed testbench for des_key_sched_ctrl using the FIPS 46-3 worked example.
module tb_des_key_sched_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic [63:0] key = '0;
    logic        decrypt = 1'b0;
    logic        abort = 1'b0;
    logic        rk_valid;
    logic        rk_ready = 1'b0;
    logic [47:0] rk;
    logic [3:0]  rk_round;
    logic        rk_last;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [47:0] exp_k [16];
    logic [63:0] fips_key;
    logic [63:0] raw_key;

    des_key_sched_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key       (key),
        .decrypt   (decrypt),
        .abort     (abort),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk        (rk),
        .rk_round  (rk_round),
        .rk_last   (rk_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fips_table();
        exp_k[0]  = 48'h1B02EFFC7072; exp_k[1]  = 48'h79AED9DBC9E5;
        exp_k[2]  = 48'h55FC8A42CF99; exp_k[3]  = 48'h72ADD6DB351D;
        exp_k[4]  = 48'h7CEC07EB53A8; exp_k[5]  = 48'h63A53E507B2F;
        exp_k[6]  = 48'hEC84B7F618BC; exp_k[7]  = 48'hF78A3AC13BFB;
        exp_k[8]  = 48'hE0DBEBEDE781; exp_k[9]  = 48'hB1F347BA464F;
        exp_k[10] = 48'h215FD3DED386; exp_k[11] = 48'h7571F59467E9;
        exp_k[12] = 48'h97C5D1FABA41; exp_k[13] = 48'h5F43B7F2E73A;
        exp_k[14] = 48'hBF918D3D3F0A; exp_k[15] = 48'hCB3D8B0E17F5;
    endtask

    task automatic set_const_table(input logic [47:0] v);
        for (int i = 0; i < 16; i++) exp_k[i] = v;
    endtask

    task automatic load(input logic [63:0] k, input logic dec, input logic ab);
        key       = k;
        decrypt   = dec;
        abort     = ab;
        key_valid = 1'b1;
        chk("load_key_ready", key_ready, 1'b1);
        step();
        key_valid = 1'b0;
        abort     = 1'b0;
    endtask

    // Expects rk_ready already high; checks n_hs keys in schedule order.
    task automatic stream(input logic dec, input int n_hs);
        int idx;
        for (int i = 0; i < n_hs; i++) begin
            idx = dec ? 15 - i : i;
            chk("rk_valid", rk_valid, 1'b1);
            chk("rk", rk, exp_k[idx]);
            chk("rk_round", rk_round, idx[3:0]);
            chk("rk_last", rk_last, (i == 15));
            step();
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_key_ready"}, key_ready, 1'b1);
        chk({tag, "_rk_valid"}, rk_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int hs;
        int cycles;
        logic rdy;

        raw_key = 64'h133457799BBCDFF1;
        for (int i = 0; i < 64; i++) fips_key[i] = raw_key[63-i];

        // Reset state
        step();
        step();
        chk("rst_key_ready", key_ready, 1'b1);
        chk("rst_rk_valid", rk_valid, 1'b0);
        chk("rst_rk", rk, 48'h0);
        chk("rst_rk_round", rk_round, 4'd0);
        chk("rst_rk_last", rk_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        step();

        // Encrypt with the FIPS example key
        set_fips_table();
        rk_ready = 1'b1;
        load(fips_key, 1'b0, 1'b0);
        stream(1'b0, 16);
        check_idle("enc_done");

        // Decrypt, same key, reverse order
        load(fips_key, 1'b1, 1'b0);
        stream(1'b1, 16);
        check_idle("dec_done");

        // Random backpressure on the encrypt schedule
        rk_ready = 1'b0;
        load(fips_key, 1'b0, 1'b0);
        hs = 0;
        cycles = 0;
        while (hs < 16 && cycles < 300) begin
            chk("bp_rk_valid", rk_valid, 1'b1);
            chk("bp_rk", rk, exp_k[hs]);
            chk("bp_rk_round", rk_round, hs[3:0]);
            chk("bp_rk_last", rk_last, (hs == 15));
            rdy = 1'($urandom_range(0, 1));
            rk_ready = rdy;
            step();
            if (rdy) hs++;
            cycles++;
        end
        rk_ready = 1'b0;
        chk("bp_handshakes", hs, 16);
        check_idle("bp_done");

        // Abort after K5, then a decrypt load offered together with abort
        rk_ready = 1'b1;
        load(fips_key, 1'b0, 1'b0);
        stream(1'b0, 5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("abort");
        chk("abort_rk_round_held", rk_round, 4'd5);
        load(fips_key, 1'b1, 1'b1);
        stream(1'b1, 16);
        check_idle("abort_dec_done");

        // Asynchronous reset after K9, checked between clock edges
        load(fips_key, 1'b0, 1'b0);
        stream(1'b0, 9);
        rst = 1'b1;
        #2;
        chk("arst_key_ready", key_ready, 1'b1);
        chk("arst_rk_valid", rk_valid, 1'b0);
        chk("arst_rk", rk, 48'h0);
        chk("arst_rk_round", rk_round, 4'd0);
        chk("arst_rk_last", rk_last, 1'b0);
        chk("arst_busy", busy, 1'b0);
        step();
        rst = 1'b0;
        step();
        check_idle("arst_idle");
        load(fips_key, 1'b0, 1'b0);
        stream(1'b0, 16);
        check_idle("arst_reload_done");

        // Degenerate keys exercise rotation wrap at both extremes
        set_const_table(48'h0);
        load(64'h0, 1'b0, 1'b0);
        stream(1'b0, 16);
        set_const_table(48'hFFFFFFFFFFFF);
        load(64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0);
        stream(1'b0, 16);
        check_idle("degen_done");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
